// File: rtl/dsm_dac.sv
// Delta-sigma DAC channel: input FIFO, frame-held data register, first- or second-order loop.
// Define DSM_SECOND_ORDER_EN for the second-order loop; the default build is first order.
module dsm_dac #(
  parameter int DW        = 16,
  parameter int OSR_LOG2  = 4,
  parameter int FIFO_LOG2 = 2
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic signed [DW-1:0] d,
  input  logic                 wd,
  output logic                 ready,
  output logic [FIFO_LOG2:0]   level,
  input  logic                 sample,
  output logic                 bs,
  output logic                 underrun,
  output logic                 overflow
);

  localparam int DEPTH = 1 << FIFO_LOG2;
  localparam int AW1   = DW + 2;
  localparam logic [FIFO_LOG2:0] FULL = (FIFO_LOG2 + 1)'(DEPTH);
  localparam logic signed [AW1-1:0] FB1 = {3'b000, {(DW - 1){1'b1}}};

  logic [DW-1:0]          mem [DEPTH];
  logic [FIFO_LOG2-1:0]   wr_ptr, rd_ptr;
  logic [OSR_LOG2-1:0]    cnt;
  logic signed [DW-1:0]   dr;
  logic                   push, pop, frame_end;
  logic signed [AW1-1:0]  x1, fb1, acc1;

  assign ready     = (level != FULL);
  assign push      = wd && ready;
  assign frame_end = sample && (cnt == '1);
  assign pop       = frame_end && (level != '0);

  // NOTE: FIFO storage has no reset; level and pointers alone define which entries are valid.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= d;
  end

  // NOTE: all state is updated with non-blocking assignments so every process sees pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      level    <= '0;
      dr       <= '0;
      cnt      <= '0;
      underrun <= 1'b0;
      overflow <= 1'b0;
    end else begin
      underrun <= frame_end && (level == '0);
      overflow <= wd && !ready;
      if (push) wr_ptr <= wr_ptr + FIFO_LOG2'(1);
      if (pop) begin
        rd_ptr <= rd_ptr + FIFO_LOG2'(1);
        dr     <= mem[rd_ptr];
      end
      case ({push, pop})
        2'b10:   level <= level + (FIFO_LOG2 + 1)'(1);
        2'b01:   level <= level - (FIFO_LOG2 + 1)'(1);
        default: level <= level;
      endcase
      if (sample) cnt <= cnt + OSR_LOG2'(1);
    end
  end

  // Feedback is the registered bit mapped to +/- (full scale - 1).
  assign x1  = {{2{dr[DW-1]}}, dr};
  assign fb1 = bs ? FB1 : -FB1;

`ifdef DSM_SECOND_ORDER_EN
  localparam int AW2 = DW + 4;
  localparam logic signed [AW2-1:0] FB2 = {5'b00000, {(DW - 1){1'b1}}};

  logic signed [AW2-1:0] acc2, fb2;

  assign fb2 = bs ? FB2 : -FB2;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      acc1 <= '0;
      acc2 <= '0;
      bs   <= 1'b0;
    end else if (sample) begin
      acc1 <= acc1 + x1 - fb1;
      acc2 <= acc2 + {{2{acc1[AW1-1]}}, acc1} - fb2;
      bs   <= !acc2[AW2-1];
    end
  end
`else
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      acc1 <= '0;
      bs   <= 1'b0;
    end else if (sample) begin
      acc1 <= acc1 + x1 - fb1;
      bs   <= !acc1[AW1-1];
    end
  end
`endif

endmodule

// File: tb/tb_dsm_dac.sv
// Directed bench for dsm_dac: reset, FIFO fill/overflow, pop order, underrun, densities.
// Second-order density checks are compiled only when DSM_SECOND_ORDER_EN is defined.
module tb_dsm_dac;

  localparam int DW        = 16;
  localparam int OSR_LOG2  = 4;
  localparam int FIFO_LOG2 = 2;

  logic                 clk    = 1'b0;
  logic                 reset  = 1'b1;
  logic [DW-1:0]        d      = '0;
  logic                 wd     = 1'b0;
  logic                 sample = 1'b0;
  logic                 ready, bs, underrun, overflow;
  logic [FIFO_LOG2:0]   level;

  int n_checks = 0;
  int n_errors = 0;
  int ones     = 0;
  int ur_cnt   = 0;
  int wraps    = 0;
  int prev_acc = 0;
  logic ur_hi  = 1'b0;
  logic ur_lo  = 1'b0;

  dsm_dac #(.DW(DW), .OSR_LOG2(OSR_LOG2), .FIFO_LOG2(FIFO_LOG2)) dut (
    .clk      (clk),
    .reset    (reset),
    .d        (d),
    .wd       (wd),
    .ready    (ready),
    .level    (level),
    .sample   (sample),
    .bs       (bs),
    .underrun (underrun),
    .overflow (overflow)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input int got, input int exp, input int tol = 0);
    n_checks++;
    if (got > exp + tol || got < exp - tol) begin
      n_errors++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h) tol %0d", tag, got, got, exp, exp, tol);
    end
  endtask

  function automatic int dr_now();
    return int'({1'b0, dut.dr});
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset  = 1'b1;
    wd     = 1'b0;
    sample = 1'b0;
    step();
    step();
    reset    = 1'b0;
    prev_acc = 0;
    step();
  endtask

  task automatic write_word(input logic [DW-1:0] w);
    d  = w;
    wd = 1'b1;
    step();
    wd = 1'b0;
  endtask

  // One sample pulse followed by one idle cycle; flags captured after each edge.
  task automatic do_sample();
    sample = 1'b1;
    step();
    ur_hi = underrun;
    if (bs) ones++;
`ifdef DSM_SECOND_ORDER_EN
    begin
      int a_new;
      a_new = dut.acc2;
      if (a_new - prev_acc > (1 << (DW + 3)) || prev_acc - a_new > (1 << (DW + 3))) wraps++;
      prev_acc = a_new;
    end
`endif
    sample = 1'b0;
    step();
    ur_lo = underrun;
    if (ur_hi) ur_cnt++;
  endtask

  task automatic run_samples(input int n);
    ones   = 0;
    ur_cnt = 0;
    for (int i = 0; i < n; i++) do_sample();
  endtask

  initial begin
    logic [DW-1:0] words [5];
    words[0] = 16'h1111;
    words[1] = 16'h2222;
    words[2] = 16'h3333;
    words[3] = 16'hC000;
    words[4] = 16'h5555;

    // Reset asserted mid-frame, away from any clock edge.
    do_reset();
    write_word(16'h1234);
    run_samples(3);
    check("bs_before_reset", int'(bs), 1);
    check("level_before_reset", int'(level), 1);
    #3 reset = 1'b1;
    #1;
    check("reset_bs", int'(bs), 0);
    check("reset_ready", int'(ready), 1);
    check("reset_level", int'(level), 0);
    check("reset_underrun", int'(underrun), 0);
    check("reset_overflow", int'(overflow), 0);
    check("reset_dr", dr_now(), 0);
    step();
    step();
    reset = 1'b0;
    step();
    run_samples(15);
    check("no_frame_end_before_16", ur_cnt, 0);
    run_samples(1);
    check("frame_end_on_16th", int'(ur_hi), 1);

    // Fill FIFO back-to-back, then one write too many.
    do_reset();
    for (int i = 0; i < 4; i++) begin
      d  = words[i];
      wd = 1'b1;
      step();
      check($sformatf("fill_level_%0d", i), int'(level), i + 1);
      check($sformatf("fill_ready_%0d", i), int'(ready), (i < 3) ? 1 : 0);
    end
    d = words[4];
    step();
    wd = 1'b0;
    check("overflow_pulse", int'(overflow), 1);
    check("overflow_level", int'(level), 4);
    step();
    check("overflow_clear", int'(overflow), 0);
    for (int i = 0; i < 4; i++) begin
      run_samples(16);
      check($sformatf("pop_dr_%0d", i), dr_now(), int'(words[i]));
      check($sformatf("pop_level_%0d", i), int'(level), 3 - i);
    end
    run_samples(16);
    check("drop_underrun", int'(ur_hi), 1);
    check("drop_dr_kept", dr_now(), 16'hC000);

    // First-order densities.
`ifndef DSM_SECOND_ORDER_EN
    do_reset();
    write_word(16'h4000);
    run_samples(16);
    check("load_4000", dr_now(), 16'h4000);
    run_samples(64);
    check("ones_4000", ones, 48, 1);
    write_word(16'h0000);
    run_samples(16);
    check("load_0000", dr_now(), 0);
    run_samples(64);
    check("ones_0000", ones, 32, 1);

    // Underrun with dr = 0xC000; the held word keeps modulating.
    do_reset();
    write_word(16'hC000);
    run_samples(16);
    run_samples(16);
    check("ones_c000_a", ones, 4, 1);
    check("underrun_pulse", int'(ur_hi), 1);
    check("underrun_one_cycle", int'(ur_lo), 0);
    check("underrun_dr_kept", dr_now(), 16'hC000);
    run_samples(16);
    check("ones_c000_b", ones, 4, 1);
`endif

    // Accepted write coinciding with a frame-end pop at level 2.
    do_reset();
    write_word(16'h0AAA);
    write_word(16'h0BBB);
    run_samples(15);
    d      = 16'h0CCC;
    wd     = 1'b1;
    sample = 1'b1;
    step();
    wd     = 1'b0;
    sample = 1'b0;
    step();
    check("simul_level", int'(level), 2);
    check("simul_dr", dr_now(), 16'h0AAA);
    run_samples(16);
    check("simul_dr_next", dr_now(), 16'h0BBB);
    check("simul_level_next", int'(level), 1);
    run_samples(16);
    check("simul_dr_last", dr_now(), 16'h0CCC);
    check("simul_level_last", int'(level), 0);

`ifdef DSM_SECOND_ORDER_EN
    do_reset();
    write_word(16'hC000);
    run_samples(16);
    run_samples(256);
    check("so_ones_c000", ones, 64, 2);
    do_reset();
    write_word(16'h7333);
    run_samples(16);
    wraps = 0;
    run_samples(256);
    check("so_ones_7333", ones, 243, 5);
    check("so_no_wrap", wraps, 0);
`endif

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
